// File: rtl/reg_dump_pkg.sv
// Shared definitions for the register-file debug blocks: geometry and the
// read-out engine state encoding.
package reg_dump_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/reg_dump.sv
// Debug read-out engine: walks an inclusive, wrapping address range over the
// register file's async read port and streams (address, data) beats out.
module reg_dump
    import reg_dump_pkg::*;
#(
    parameter int DATA_WIDTH = reg_dump_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = reg_dump_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] first_addr,
    input  logic [ADDR_WIDTH-1:0] last_addr,
    output logic [ADDR_WIDTH-1:0] raddr,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   cur_q;
    logic [ADDR_WIDTH-1:0]   last_q;
    logic                    out_valid_q;
    logic [ADDR_WIDTH-1:0]   out_addr_q;
    logic [DATA_WIDTH-1:0]   out_data_q;
    logic                    out_last_q;

    // NOTE: sequential state uses non-blocking assignments only; every register
    // here is small control/data state, so all of it is cleared on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            last_q      <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cur_q   <= first_addr;
                        last_q  <= last_addr;
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    // rdata reflects the pre-write value if the file writes cur_q on this edge.
                    out_data_q  <= rdata;
                    out_addr_q  <= cur_q;
                    out_last_q  <= (cur_q == last_q);
                    out_valid_q <= 1'b1;
                    state_q     <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (out_last_q) begin
                            state_q <= DONE;
                        end else begin
                            cur_q   <= cur_q + 1'b1;
                            state_q <= FETCH;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign raddr     = (state_q == FETCH || state_q == SEND) ? cur_q : '0;
    assign busy      = (state_q == FETCH || state_q == SEND);
    assign done      = (state_q == DONE);
    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_reg_dump.sv
// Scoreboard bench for reg_dump: stimulus queues expected beats, a monitor
// pops and compares them at each handshake and watches hold/done behaviour.
module tb_reg_dump;
    import reg_dump_pkg::*;

    localparam int DW = DATA_WIDTH;
    localparam int AW = ADDR_WIDTH;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] first_addr;
    logic [AW-1:0] last_addr;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    reg_dump dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .raddr      (raddr),
        .rdata      (rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    // Register file model: async read, write on rising edge.
    logic [DW-1:0] regs [0:(1<<AW)-1];
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    assign rdata = regs[raddr];
    always @(posedge clk) if (wr_en) regs[wr_addr] <= wr_data;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    hs_count = 0;
    int    last_hs_cyc = 0;
    int    t_start = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compares beats at handshakes, checks held outputs and done pulse.
    logic  hold_pend = 1'b0;
    logic  hs_last_pend = 1'b0;
    beat_t held;
    beat_t e;
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("done_pulse", 64'(done), 64'(hs_last_pend));
            if (hold_pend)
                check("hold_stable", {out_valid, out_addr, out_data, out_last}, {1'b1, held});
            hold_pend    = out_valid && !out_ready;
            held         = {out_addr, out_data, out_last};
            hs_last_pend = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got addr %0d data 0x%0h, none expected", out_addr, out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_addr", 64'(out_addr), 64'(e.addr));
                    check("beat_data", 64'(out_data), 64'(e.data));
                    check("beat_last", 64'(out_last), 64'(e.last));
                end
                hs_count++;
                if (out_last) begin
                    hs_last_pend = 1'b1;
                    last_hs_cyc  = cyc + 1;
                end
            end
        end else begin
            hold_pend    = 1'b0;
            hs_last_pend = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int a, input logic [DW-1:0] d, input bit l);
        beat_t b;
        b.addr = a[AW-1:0];
        b.data = d;
        b.last = l;
        exp_q.push_back(b);
    endtask

    task automatic start_dump(input int f, input int l);
        first_addr = f[AW-1:0];
        last_addr  = l[AW-1:0];
        start      = 1'b1;
        tick();
        start   = 1'b0;
        t_start = cyc;
    endtask

    task automatic wait_done(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check(name, 64'(got), 64'd1);
        check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r0;
        rst_n      = 1'b0;
        start      = 1'b0;
        first_addr = '0;
        last_addr  = '0;
        out_ready  = 1'b1;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        for (int i = 0; i < (1 << AW); i++) regs[i] = DW'(i);
        regs[1] = 32'h1111_1111;
        regs[2] = 32'h2222_2222;
        regs[3] = 32'h3333_3333;
        regs[7] = 32'hDEAD_BEEF;

        // Reset state
        tick();
        tick();
        check("reset_outputs", {out_valid, out_last, out_addr, out_data, busy, done, raddr}, 64'd0);
        rst_n = 1'b1;
        tick();

        // Basic range 1..3, ready held high
        push(1, 32'h1111_1111, 1'b0);
        push(2, 32'h2222_2222, 1'b0);
        push(3, 32'h3333_3333, 1'b1);
        start_dump(1, 3);
        check("fetch_busy", 64'(busy), 64'd1);
        check("fetch_raddr", 64'(raddr), 64'd1);
        check("fetch_no_valid", 64'(out_valid), 64'd0);
        wait_done("done_1_3");
        check("three_beat_span", 64'(last_hs_cyc - t_start), 64'd6);
        check("idle_raddr", 64'(raddr), 64'd0);

        // Wrapping range 30..1
        push(30, 32'd30, 1'b0);
        push(31, 32'd31, 1'b0);
        push(0, 32'd0, 1'b0);
        push(1, 32'h1111_1111, 1'b1);
        start_dump(30, 1);
        wait_done("done_wrap");

        // Back-pressure on r7
        out_ready = 1'b0;
        push(7, 32'hDEAD_BEEF, 1'b1);
        start_dump(7, 7);
        tick();
        check("stall_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) tick();
        out_ready = 1'b1;
        r0 = cyc;
        wait_done("done_stall");
        check("stall_release", 64'(last_hs_cyc - r0), 64'd1);

        // Same-edge write hazard on r5: old value captured, re-dump sees new
        push(5, 32'h0000_0005, 1'b1);
        start_dump(5, 5);
        wr_en   = 1'b1;
        wr_addr = 5'd5;
        wr_data = 32'hCAFE_F00D;
        tick();
        wr_en = 1'b0;
        wait_done("done_hazard");
        push(5, 32'hCAFE_F00D, 1'b1);
        start_dump(5, 5);
        wait_done("done_redump");

        // Reset during second beat of full dump
        for (int i = 0; i < 32; i++) push(i, regs[i], i == 31);
        out_ready = 1'b0;
        start_dump(0, 31);
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        check("second_beat_addr", 64'(out_addr), 64'd1);
        rst_n = 1'b0;
        tick();
        check("midreset_outputs", {out_valid, out_last, out_addr, out_data, busy, done, raddr}, 64'd0);
        rst_n = 1'b1;
        exp_q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 32; i++) push(i, regs[i], i == 31);
        start_dump(0, 31);
        wait_done("done_full");
        check("full_dump_cycles", 64'(last_hs_cyc - t_start), 64'd64);

        // start while busy is ignored; single-beat range 9..9
        push(1, 32'h1111_1111, 1'b0);
        push(2, 32'h2222_2222, 1'b0);
        push(3, 32'h3333_3333, 1'b1);
        start_dump(1, 3);
        tick();
        first_addr = 5'd9;
        last_addr  = 5'd9;
        start      = 1'b1;
        tick();
        tick();
        start = 1'b0;
        wait_done("done_ignore_start");
        tick();
        check("idle_after_ignore", 64'(busy), 64'd0);
        push(9, 32'd9, 1'b1);
        start_dump(9, 9);
        wait_done("done_single");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
